mac_out_quant: RTL and testbench

Downstream stage of the MAC unit. It captures each 40-bit accumulator value the MAC presents with its `ready_mac` pulse, then rounds, shifts and saturates it to a 16-bit fixed-point result. Results are buffered in a small FIFO and delivered over a valid/ready stream. The MAC has no backpressure, so overflow of the buffer is detected and flagged rather than stalled.

---
 rtl/mac_out_quant_if.sv | 13 +
 rtl/mac_out_quant.sv | 184 ++++++++++++++++++
 tb/tb_mac_out_quant.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mac_out_quant_if.sv
// Result stream of mac_out_quant: quantized head sample, its saturation tag
// and the valid/ready handshake with the consumer.
interface mac_out_quant_if #(
  parameter int OUT_WIDTH = 16
) ();
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_sat, output out_valid, input out_ready);
  modport slave  (input out_data, input out_sat, input out_valid, output out_ready);
endinterface

// File: rtl/mac_out_quant.sv
// MAC output quantizer: shift/saturate accumulator to OUT_WIDTH and buffer in a FIFO.
// Build option MAC_QUANT_ROUND_EN selects round-half-up; otherwise truncation (floor).
module mac_out_quant #(
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ACC_WIDTH-1:0]          acc_in,
  input  logic                          acc_valid,
  mac_out_quant_if.master               out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_sticky,
  output logic                          drop_err,
  input  logic                          clr_flags
);

  localparam int EXT_W = ACC_WIDTH + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int ENT_W = OUT_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Clamp a shifted value to OUT_WIDTH; returns {sat, data}.
  function automatic logic [ENT_W-1:0] sat_q(input logic signed [EXT_W-1:0] v);
    logic [ENT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, v[OUT_WIDTH-1:0]};
    end
    return r;
  endfunction

  logic signed [EXT_W-1:0] acc_ext_s;
  logic signed [EXT_W-1:0] acc_rnd_s;
  logic signed [EXT_W-1:0] acc_shr_s;
  logic signed [EXT_W-1:0] s1_data_r;
  logic                    s1_valid_r;

  logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [ENT_W-1:0] head_r, head_nxt_s, push_word_s;
  logic             out_valid_r;
  logic             sat_sticky_r, sat_sticky_nxt_s;
  logic             drop_err_r, drop_err_nxt_s;
  logic             pop_s, push_s, drop_s, full_s;

  assign acc_ext_s = {acc_in[ACC_WIDTH-1], acc_in};
`ifdef MAC_QUANT_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_K = {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  // Extension by one bit guarantees the half-LSB add cannot wrap.
  assign acc_rnd_s = acc_ext_s + RND_K;
`else
  assign acc_rnd_s = acc_ext_s;
`endif
  assign acc_shr_s   = acc_rnd_s >>> FRAC_SHIFT;
  assign push_word_s = sat_q(s1_data_r);

  // S1 capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {EXT_W{1'b0}};
    end else begin
      s1_valid_r <= acc_valid;
      if (acc_valid) begin
        s1_data_r <= acc_shr_s;
      end else begin
        s1_data_r <= s1_data_r;
      end
    end
  end

  // FIFO control, next head and sticky flag logic.
  always_comb begin
    pop_s            = out_valid_r & out_if.out_ready;
    full_s           = (count_r == FULL_CNT);
    push_s           = s1_valid_r & (~full_s | pop_s);
    drop_s           = s1_valid_r & full_s & ~pop_s;
    wr_ptr_nxt_s     = wr_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    count_nxt_s      = count_r;
    head_nxt_s       = {ENT_W{1'b0}};
    sat_sticky_nxt_s = sat_sticky_r;
    drop_err_nxt_s   = drop_err_r;

    case ({push_s, pop_s})
      2'b10: begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1'b1);
        count_nxt_s  = count_r + CW'(1'b1);
      end
      2'b01: begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1'b1);
        count_nxt_s  = count_r - CW'(1'b1);
      end
      2'b11: begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1'b1);
        rd_ptr_nxt_s = rd_ptr_r + PW'(1'b1);
      end
      default: begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
      end
    endcase

    // Head is registered, so a push landing in the next head slot is forwarded.
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = {ENT_W{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_word_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end

    if (push_s && push_word_s[OUT_WIDTH]) begin
      sat_sticky_nxt_s = 1'b1;
    end else if (clr_flags) begin
      sat_sticky_nxt_s = 1'b0;
    end else begin
      sat_sticky_nxt_s = sat_sticky_r;
    end

    if (drop_s) begin
      drop_err_nxt_s = 1'b1;
    end else if (clr_flags) begin
      drop_err_nxt_s = 1'b0;
    end else begin
      drop_err_nxt_s = drop_err_r;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy, registered head and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_r       <= {ENT_W{1'b0}};
      out_valid_r  <= 1'b0;
      sat_sticky_r <= 1'b0;
      drop_err_r   <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      head_r       <= head_nxt_s;
      out_valid_r  <= (count_nxt_s != {CW{1'b0}});
      sat_sticky_r <= sat_sticky_nxt_s;
      drop_err_r   <= drop_err_nxt_s;
    end
  end

  assign out_if.out_data  = head_r[OUT_WIDTH-1:0];
  assign out_if.out_sat   = head_r[OUT_WIDTH];
  assign out_if.out_valid = out_valid_r;
  assign fifo_count       = count_r;
  assign sat_sticky       = sat_sticky_r;
  assign drop_err         = drop_err_r;

endmodule

// File: tb/tb_mac_out_quant.sv
// Directed-vector bench for mac_out_quant; expectations follow MAC_QUANT_ROUND_EN.
module tb_mac_out_quant;

  logic        clk;
  logic        rst_n;
  logic [39:0] acc_in;
  logic        acc_valid;
  logic [2:0]  fifo_count;
  logic        sat_sticky;
  logic        drop_err;
  logic        clr_flags;
  int          tests_run;
  int          tests_failed;

`ifdef MAC_QUANT_ROUND_EN
  localparam logic [15:0] EXP_HALF = 16'h0001;
  localparam logic [15:0] EXP_NEG  = 16'hFFFF;
`else
  localparam logic [15:0] EXP_HALF = 16'h0000;
  localparam logic [15:0] EXP_NEG  = 16'hFFFE;
`endif

  mac_out_quant_if #(.OUT_WIDTH(16)) out_if ();

  mac_out_quant #(
    .ACC_WIDTH(40), .OUT_WIDTH(16), .FRAC_SHIFT(15), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_valid(acc_valid),
    .out_if(out_if), .fifo_count(fifo_count), .sat_sticky(sat_sticky),
    .drop_err(drop_err), .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [39:0] v);
    acc_in    = v;
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    acc_in    = 40'h0;
  endtask

  task automatic pop_one();
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
  endtask

  // Single sample through an empty FIFO: latency, value, sat tag, then drain.
  task automatic send_check(input string tag, input logic [39:0] v,
                            input logic [15:0] exp_d, input logic exp_s);
    strobe(v);
    check_eq({tag, "_lat"}, 64'(out_if.out_valid), 64'(1'b0));
    tick();
    check_eq({tag, "_valid"}, 64'(out_if.out_valid), 64'(1'b1));
    check_eq({tag, "_data"}, 64'(out_if.out_data), 64'(exp_d));
    check_eq({tag, "_sat"}, 64'(out_if.out_sat), 64'(exp_s));
    pop_one();
    check_eq({tag, "_empty"}, 64'(fifo_count), 64'(3'd0));
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    rst_n            = 1'b0;
    acc_in           = 40'h0;
    acc_valid        = 1'b0;
    clr_flags        = 1'b0;
    out_if.out_ready = 1'b0;
    #12;
    check_eq("rst_valid", 64'(out_if.out_valid), 64'(1'b0));
    check_eq("rst_data", 64'(out_if.out_data), 64'(16'h0000));
    check_eq("rst_sat", 64'(out_if.out_sat), 64'(1'b0));
    check_eq("rst_count", 64'(fifo_count), 64'(3'd0));
    check_eq("rst_sticky", 64'(sat_sticky), 64'(1'b0));
    check_eq("rst_drop", 64'(drop_err), 64'(1'b0));
    rst_n = 1'b1;
    tick();

    send_check("half", 40'h0000004000, EXP_HALF, 1'b0);
    send_check("neg", 40'hFFFFFF4000, EXP_NEG, 1'b0);
    send_check("maxok", 40'h003FFF8000, 16'h7FFF, 1'b0);
    check_eq("sticky_none", 64'(sat_sticky), 64'(1'b0));
    send_check("satpos", 40'h0040000000, 16'h7FFF, 1'b1);
    check_eq("sticky_pos", 64'(sat_sticky), 64'(1'b1));
    send_check("minok", 40'hFFC0000000, 16'h8000, 1'b0);
    send_check("satneg", 40'hFFBFFF8000, 16'h8000, 1'b1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("sticky_clr", 64'(sat_sticky), 64'(1'b0));

    // Overflow: five back-to-back strobes with the consumer stalled.
    for (int k = 1; k <= 5; k++) strobe(40'(k) << 15);
    tick();
    check_eq("full_count", 64'(fifo_count), 64'(3'd4));
    check_eq("full_drop", 64'(drop_err), 64'(1'b1));
    tick();
    check_eq("full_hold", 64'(out_if.out_data), 64'(16'h0001));
    out_if.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("drain_data", 64'(out_if.out_data), 64'(k));
      tick();
    end
    out_if.out_ready = 1'b0;
    check_eq("drain_valid", 64'(out_if.out_valid), 64'(1'b0));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("drop_clr", 64'(drop_err), 64'(1'b0));

    // Push and pop on the same edge while full.
    for (int k = 1; k <= 4; k++) strobe(40'(k) << 15);
    tick();
    check_eq("pp_full", 64'(fifo_count), 64'(3'd4));
    strobe(40'(6) << 15);
    pop_one();
    check_eq("pp_drop", 64'(drop_err), 64'(1'b0));
    check_eq("pp_count", 64'(fifo_count), 64'(3'd4));
    out_if.out_ready = 1'b1;
    check_eq("pp_d0", 64'(out_if.out_data), 64'(16'd2)); tick();
    check_eq("pp_d1", 64'(out_if.out_data), 64'(16'd3)); tick();
    check_eq("pp_d2", 64'(out_if.out_data), 64'(16'd4)); tick();
    check_eq("pp_d3", 64'(out_if.out_data), 64'(16'd6)); tick();
    out_if.out_ready = 1'b0;
    check_eq("pp_empty", 64'(fifo_count), 64'(3'd0));

    // Clear on the same edge as a saturating push: set wins.
    strobe(40'h0040000000);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("clr_vs_set", 64'(sat_sticky), 64'(1'b1));
    pop_one();

    // Asynchronous reset with three queued entries and S1 occupied.
    for (int k = 1; k <= 4; k++) strobe(40'(k) << 15);
    check_eq("mid_count", 64'(fifo_count), 64'(3'd3));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_valid", 64'(out_if.out_valid), 64'(1'b0));
    check_eq("mid_cnt0", 64'(fifo_count), 64'(3'd0));
    check_eq("mid_sticky", 64'(sat_sticky), 64'(1'b0));
    tick();
    check_eq("mid_hold", 64'(out_if.out_valid), 64'(1'b0));
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_idle", 64'(out_if.out_valid), 64'(1'b0));
    send_check("post", 40'(7) << 15, 16'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
